ro_meas_sequencer: RTL and testbench
====================================

# ro_meas_sequencer

Measurement sequencer for the ring-oscillator sensor path. It alternates the oscillator between stress and measure configuration, opens a fixed gate window on the edge counter, and computes the ring-edge count for that window from counter snapshots. It then presents the count to the display controller with a one-cycle valid strobe. It sits between the ring oscillator/counter pair and the seven-segment display controller, replacing the hard-tied enable.

## Interface
- STRESS_CYCLES, default 1000000: clocks the oscillator is held in stress per run; 0 skips stress.
- SETTLE_CYCLES, default 1000: clocks in measure mode before the gate opens; minimum 1.
- GATE_CYCLES, default 50000: clocks cnt_enable is high per window; minimum 1.
- CNT_W, default 16: counter/result width.
- fpga_clk1  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; ignored while busy.
- continuous  in  1  when high, a finished run immediately restarts.
- abort  in  1  returns the sequencer to IDLE on the next edge; no result is produced.
- cnt_value  in  CNT_W  free-running edge count from the counting circuit; wraps modulo 2^CNT_W.
- ro_stress  out  1  oscillator stress select.
- ro_mode  out  1  oscillator measure-mode select.
- cnt_enable  out  1  counter gate.
- busy  out  1  high in every state except IDLE.
- result  out  CNT_W  last completed window count; held until the next completion.
- result_valid  out  1  one-cycle strobe when result updates.

## Operation
- States: IDLE, STRESS, SETTLE, SNAP, GATE, DRAIN, CAPTURE.
- IDLE: all outputs 0 except result (held). start=1 moves to STRESS, or to SETTLE if STRESS_CYCLES=0.
- STRESS: ro_stress=1, ro_mode=0 for exactly STRESS_CYCLES clocks, then SETTLE.
- SETTLE: ro_stress=0, ro_mode=1 for SETTLE_CYCLES clocks, then SNAP.
- SNAP: one clock; registers cnt_value into snap_start; cnt_enable=0.
- GATE: cnt_enable=1 for exactly GATE_CYCLES clocks, then DRAIN.
- DRAIN: two clocks with cnt_enable=0 to absorb counter pipeline latency.
- CAPTURE: one clock; result <= cnt_value - snap_start (modulo 2^CNT_W, so counter wrap is transparent), result_valid=1. Next state is STRESS/SETTLE if continuous=1, else IDLE.
- ro_mode stays 1 from SETTLE through CAPTURE.
- A window longer than 2^CNT_W edges aliases; sizing GATE_CYCLES is the integrator's responsibility.
- abort has priority over every transition, start and continuous. result is not modified.
- start asserted in the same cycle as abort is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, result 0, snap_start 0, timers 0.
- All outputs are registered. cnt_enable rises on the edge leaving SNAP and falls exactly GATE_CYCLES edges later.
- start-to-result_valid latency, single window: STRESS_CYCLES + SETTLE_CYCLES + 1 + GATE_CYCLES + 2 + 1 clocks after the start edge.
- Continuous mode has no idle gap: CAPTURE is followed directly by STRESS.
- reset_n low mid-run forces all outputs to 0 immediately, without waiting for a clock edge.

## Configuration
- RO_SEQ_AVG_EN defined: each run performs SNAP/GATE/DRAIN four times after one SETTLE. Window counts accumulate in a CNT_W+2-bit sum. CAPTURE outputs sum>>2 (truncated). result_valid pulses once per run.
- RO_SEQ_AVG_EN undefined: single window per run, with no accumulator logic.

## Structure
- Shared package ro_seq_pkg holds the state enum, the DRAIN_CYCLES=2 constant and the averaging count 4.
- One sub-module, seq_timer: a loadable down-counter with a done flag. It is reused for the stress, settle, gate and drain durations.

## Test plan
- Parameters used: STRESS=8, SETTLE=4, GATE=16. The counter model adds 3 per enabled clock, starting at 0. Pulse start -> result=48, result_valid for 1 clock at cycle 32 after start; ro_stress high for exactly 8 clocks.
- Wrap: the counter model preset to 0xFFF0 -> result=48.
- Abort: abort asserted during GATE -> IDLE next clock, cnt_enable=0, no result_valid, previous result unchanged.
- Continuous: continuous=1 for 3 runs -> three result_valid strobes exactly 32 clocks apart; start pulses while busy have no effect.
- Reset: reset_n dropped during STRESS -> ro_stress=0 immediately. The first run after release behaves as in the first scenario.
- With RO_SEQ_AVG_EN, window increments of 2, 3, 3, 4 per clock -> window counts 32, 48, 48, 64, sum 192, result=48.

Source files
------------

// File: rtl/ro_meas_sequencer_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STRESS,
      S_SETTLE,
      S_SNAP,
      S_GATE,
      S_DRAIN,
      S_CAPTURE
   } seq_state_t;

   localparam int unsigned DRAIN_CYCLES = 2;
   localparam int unsigned AVG_WINDOWS  = 4;
   localparam int unsigned TMR_W        = 32;

   // A state lasting n clocks loads n-1; n=0 is treated as a single clock.
   function automatic logic [TMR_W-1:0] tmr_load_val(input int unsigned n);
      return (n == 0) ? '0 : TMR_W'(n - 1);
   endfunction

endpackage

// File: rtl/ro_meas_sequencer_if.sv
// Control/data bundle between the sequencer, the RO/counter pair and the display path.
interface ro_meas_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             continuous;
   logic             abort;
   logic [CNT_W-1:0] cnt_value;
   logic             ro_stress;
   logic             ro_mode;
   logic             cnt_enable;
   logic             busy;
   logic [CNT_W-1:0] result;
   logic             result_valid;

   modport master (
      output start, continuous, abort, cnt_value,
      input  ro_stress, ro_mode, cnt_enable, busy, result, result_valid
   );

   modport slave (
      input  start, continuous, abort, cnt_value,
      output ro_stress, ro_mode, cnt_enable, busy, result, result_valid
   );
endinterface

// File: rtl/ro_meas_sequencer_seq_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module seq_timer
   import ro_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [TMR_W-1:0] i_load_val,
   output logic             o_done
);

   logic [TMR_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ro_meas_sequencer.sv
// Stress/settle/gate sequencer producing a per-window ring-edge count.
// Optional RO_SEQ_AVG_EN: four gate windows per run, result is their truncated mean.
module ro_meas_sequencer
   import ro_seq_pkg::*;
#(
   parameter int unsigned STRESS_CYCLES = 1000000,
   parameter int unsigned SETTLE_CYCLES = 1000,
   parameter int unsigned GATE_CYCLES   = 50000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                fpga_clk1,
   input  logic                reset_n,
   ro_meas_sequencer_if.slave  bus
);

   localparam seq_state_t       FIRST_ST   = (STRESS_CYCLES == 0) ? S_SETTLE : S_STRESS;
   localparam logic [TMR_W-1:0] FIRST_LOAD = (STRESS_CYCLES == 0) ? tmr_load_val(SETTLE_CYCLES)
                                                                   : tmr_load_val(STRESS_CYCLES);

   seq_state_t       r_state;
   seq_state_t       w_nxt;
   logic             w_tmr_load;
   logic [TMR_W-1:0] w_tmr_val;
   logic             w_tmr_done;
   logic             w_last_win;
   logic [CNT_W-1:0] w_win_cnt;
   logic [CNT_W-1:0] r_snap_start;
   logic [CNT_W-1:0] r_result;
   logic             r_result_valid;
   logic             r_ro_stress;
   logic             r_ro_mode;
   logic             r_cnt_en;
   logic             r_busy;

   seq_timer u_timer (
      .i_clk      (fpga_clk1),
      .i_rst_n    (reset_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

   // Wrap-safe: modular subtraction hides counter rollover inside the window.
   assign w_win_cnt = bus.cnt_value - r_snap_start;

`ifdef RO_SEQ_AVG_EN
   localparam int unsigned WIN_W = $clog2(AVG_WINDOWS);

   logic [CNT_W+1:0] r_sum;
   logic [WIN_W-1:0] r_win;

   assign w_last_win = (r_win == WIN_W'(AVG_WINDOWS - 1));

   always_ff @(posedge fpga_clk1 or negedge reset_n) begin
      if (!reset_n) begin
         r_sum <= '0;
         r_win <= '0;
      end else if (r_state == S_IDLE || r_state == S_CAPTURE) begin
         r_sum <= '0;
         r_win <= '0;
      end else if (r_state == S_DRAIN && w_tmr_done && !bus.abort) begin
         r_sum <= r_sum + {2'b00, w_win_cnt};
         r_win <= r_win + 1'b1;
      end
   end
`else
   assign w_last_win = 1'b1;
`endif

   // Timer loads coincide with entry into each timed state.
   always_comb begin
      w_nxt      = r_state;
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      if (bus.abort) begin
         w_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (bus.start) begin
               w_nxt      = FIRST_ST;
               w_tmr_load = 1'b1;
               w_tmr_val  = FIRST_LOAD;
            end
            S_STRESS: if (w_tmr_done) begin
               w_nxt      = S_SETTLE;
               w_tmr_load = 1'b1;
               w_tmr_val  = tmr_load_val(SETTLE_CYCLES);
            end
            S_SETTLE: if (w_tmr_done) w_nxt = S_SNAP;
            S_SNAP: begin
               w_nxt      = S_GATE;
               w_tmr_load = 1'b1;
               w_tmr_val  = tmr_load_val(GATE_CYCLES);
            end
            S_GATE: if (w_tmr_done) begin
               w_nxt      = S_DRAIN;
               w_tmr_load = 1'b1;
               w_tmr_val  = tmr_load_val(DRAIN_CYCLES);
            end
            S_DRAIN: if (w_tmr_done) w_nxt = w_last_win ? S_CAPTURE : S_SNAP;
            S_CAPTURE: begin
               if (bus.continuous) begin
                  w_nxt      = FIRST_ST;
                  w_tmr_load = 1'b1;
                  w_tmr_val  = FIRST_LOAD;
               end else begin
                  w_nxt = S_IDLE;
               end
            end
            default: w_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge fpga_clk1 or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_ro_stress    <= 1'b0;
         r_ro_mode      <= 1'b0;
         r_cnt_en       <= 1'b0;
         r_busy         <= 1'b0;
         r_snap_start   <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else begin
         r_state        <= w_nxt;
         r_ro_stress    <= (w_nxt == S_STRESS);
         r_ro_mode      <= (w_nxt inside {[S_SETTLE:S_CAPTURE]});
         r_cnt_en       <= (w_nxt == S_GATE);
         r_busy         <= (w_nxt != S_IDLE);
         r_result_valid <= 1'b0;
         if (r_state == S_SNAP) begin
            r_snap_start <= bus.cnt_value;
         end
         if (r_state == S_CAPTURE && !bus.abort) begin
`ifdef RO_SEQ_AVG_EN
            r_result <= r_sum[CNT_W+1:2];
`else
            r_result <= w_win_cnt;
`endif
            r_result_valid <= 1'b1;
         end
      end
   end

   assign bus.ro_stress    = r_ro_stress;
   assign bus.ro_mode      = r_ro_mode;
   assign bus.cnt_enable   = r_cnt_en;
   assign bus.busy         = r_busy;
   assign bus.result       = r_result;
   assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Scoreboard bench for ro_meas_sequencer; honours RO_SEQ_AVG_EN when defined.
module tb_ro_meas_sequencer;
   import ro_seq_pkg::*;

   localparam int unsigned STRESS = 8;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned GATE   = 16;
   localparam int unsigned CW     = 16;
`ifdef RO_SEQ_AVG_EN
   localparam int LAT = STRESS + SETTLE + 4 * (1 + GATE + 2) + 1;
`else
   localparam int LAT = STRESS + SETTLE + 1 + GATE + 2 + 1;
`endif

   typedef struct {
      logic [CW-1:0] res;
      int            cyc;
   } exp_t;

   logic     clk   = 1'b0;
   logic     rst_n = 1'b0;
   int       cyc   = 0;
   int       n_vec = 0;
   int       n_err = 0;
   int       stress_total = 0;
   exp_t     sb[$];

   logic [CW-1:0] m_cnt = '0;
   logic [CW-1:0] m_pv  = '0;
   logic          m_pre = 1'b0;
   logic          m_en_d = 1'b0;
   int            m_win = 0;

   ro_meas_sequencer_if #(.CNT_W(CW)) bus ();

   ro_meas_sequencer #(
      .STRESS_CYCLES (STRESS),
      .SETTLE_CYCLES (SETTLE),
      .GATE_CYCLES   (GATE),
      .CNT_W         (CW)
   ) dut (
      .fpga_clk1 (clk),
      .reset_n   (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [CW-1:0] win_inc(input int w);
`ifdef RO_SEQ_AVG_EN
      case (w % 4)
         0:       return 16'd2;
         3:       return 16'd4;
         default: return 16'd3;
      endcase
`else
      return (w >= 0) ? 16'd3 : 16'd3;
`endif
   endfunction

   // Edge-counter model: free-running, advances only while the gate is open.
   always @(posedge clk) begin
      m_en_d <= bus.cnt_enable;
      if (m_pre) begin
         m_cnt <= m_pv;
         m_win <= 0;
      end else begin
         if (bus.cnt_enable) m_cnt <= m_cnt + win_inc(m_win);
         if (m_en_d && !bus.cnt_enable) m_win <= m_win + 1;
      end
   end
   assign bus.cnt_value = m_cnt;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.ro_stress) stress_total++;
      if (rst_n && bus.result_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 32'(bus.result), 32'(e.res));
            check("latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic preset(input logic [CW-1:0] v);
      @(negedge clk);
      m_pv  = v;
      m_pre = 1'b1;
      @(negedge clk);
      m_pre = 1'b0;
   endtask

   task automatic pulse_start(input bit expect_result);
      @(negedge clk);
      bus.start = 1'b1;
      if (expect_result) sb.push_back('{res: 16'd48, cyc: cyc + 1 + LAT});
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("sb_drain", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      int s0;
      int c_start;
      int n;
      bus.start      = 1'b0;
      bus.continuous = 1'b0;
      bus.abort      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ctl", {28'd0, bus.ro_stress, bus.ro_mode, bus.cnt_enable, bus.busy}, 32'd0);
      check("rst_result", {15'd0, bus.result_valid, bus.result}, 32'd0);
      rst_n = 1'b1;

      // Single run
      preset('0);
      s0 = stress_total;
      pulse_start(1'b1);
      wait_drain(LAT + 10);
      check("stress_clks", 32'(stress_total - s0), 32'(STRESS));
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Counter wrap inside the window
      preset(16'hFFF0);
      pulse_start(1'b1);
      wait_drain(LAT + 10);

      // Abort during GATE, with a coincident start that must be ignored
      preset('0);
      pulse_start(1'b0);
      n = 0;
      while (!bus.cnt_enable && n < 4 * LAT) begin
         @(negedge clk);
         n++;
      end
      check("gate_reached", 32'(bus.cnt_enable), 32'd1);
      repeat (3) @(negedge clk);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      check("abort_ctl", {29'd0, bus.cnt_enable, bus.busy, bus.ro_mode}, 32'd0);
      repeat (LAT + 10) @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_result", 32'(bus.result), 32'd48);

      // Continuous: three back-to-back runs, start pulses while busy ignored
      preset('0);
      @(negedge clk);
      c_start = cyc + 1;
      bus.start      = 1'b1;
      bus.continuous = 1'b1;
      for (int k = 1; k <= 3; k++) sb.push_back('{res: 16'd48, cyc: c_start + k * LAT});
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < c_start + LAT + 3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < c_start + 2 * LAT + 2) @(negedge clk);
      bus.continuous = 1'b0;
      wait_drain(2 * LAT);
      repeat (LAT + 5) @(negedge clk);
      check("cont_idle", 32'(bus.busy), 32'd0);

      // Asynchronous reset during STRESS
      preset('0);
      pulse_start(1'b0);
      repeat (3) @(negedge clk);
      check("in_stress", 32'(bus.ro_stress), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_stress", 32'(bus.ro_stress), 32'd0);
      check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("async_rst_result", 32'(bus.result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      preset('0);
      s0 = stress_total;
      pulse_start(1'b1);
      wait_drain(LAT + 10);
      check("post_rst_stress", 32'(stress_total - s0), 32'(STRESS));

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
